// File: rtl/fast_inv_sqrt_iter.sv
// fast_inv_sqrt_iter
//   Sequential binary32 approximation of 1/sqrt(x). The seed comes from the
//   magic-constant integer trick and is then refined by NEWTON_ITERS
//   Newton-Raphson steps y = y * (1.5 - xhalf*y*y). One FP32 multiplier and
//   one FP32 subtractor are shared across the iteration by the FSM.
//   Special inputs (zero/denormal, NaN, negative, +inf) are classified at
//   accept time and override the datapath result when it is presented.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake, in_data = x (binary32)
//   out_valid/out_ready result handshake, out_data = 1/sqrt(x) (binary32)
//   out_invalid         x was NaN or negative nonzero
//   out_dbz             x was +/-0 or denormal
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an operand
// SEED   | y = MAGIC - (x>>1), xhalf = x/2, k = 0
// SQ     | t = y*y
// MXY    | t = xhalf*t
// SUB    | t = 1.5 - t
// MY     | y = y*t, k++
// DONE   | result presented until out_ready
module fast_inv_sqrt_iter #(
  parameter int unsigned NEWTON_ITERS = 2,
  parameter logic [31:0] MAGIC        = 32'h5F3759DF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_dbz
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SQ, S_MXY, S_SUB, S_MY, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_NORMAL, C_DBZ, C_INVALID, C_PINF
  } class_t;

  localparam logic [31:0] THREE_HALVES = 32'h3FC00000;
  localparam logic [2:0]  ITERS        = 3'(NEWTON_ITERS);

  // Truncating multiply; denormal/zero operands give +0.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       prod;
    logic signed [9:0] exp_s;
    logic [22:0]       frac;
    logic              sign;
    sign = a[31] ^ b[31];
    prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (prod[47]) begin
      frac  = prod[46:24];
      exp_s = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd126;
    end else begin
      frac  = prod[45:23];
      exp_s = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    end
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || exp_s <= 10'sd0)
      fp_mul = 32'h0000_0000;
    else if (exp_s >= 10'sd255)
      fp_mul = {sign, 8'hFE, 23'h7FFFFF};
    else
      fp_mul = {sign, exp_s[7:0], frac};
  endfunction

  // Truncating a - b; denormal operands are treated as zero.
  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    logic [30:0]       av, bv;
    logic [31:0]       big, sml;
    logic [23:0]       mb, ms, ms_sh, diff, norm;
    logic [24:0]       sum;
    logic [7:0]        d;
    logic [8:0]        e_add;
    logic [4:0]        lz;
    logic signed [9:0] en;
    av = (a[30:23] == 8'h00) ? 31'h0 : a[30:0];
    bv = (b[30:23] == 8'h00) ? 31'h0 : b[30:0];
    if (av >= bv) begin
      big = {a[31], av};
      sml = {~b[31], bv};
    end else begin
      big = {~b[31], bv};
      sml = {a[31], av};
    end
    mb    = (big[30:23] == 8'h00) ? 24'h0 : {1'b1, big[22:0]};
    ms    = (sml[30:23] == 8'h00) ? 24'h0 : {1'b1, sml[22:0]};
    d     = big[30:23] - sml[30:23];
    ms_sh = (d >= 8'd24) ? 24'h0 : (ms >> d);
    sum   = 25'h0;
    diff  = 24'h0;
    norm  = 24'h0;
    e_add = 9'h0;
    lz    = 5'd0;
    en    = 10'sd0;
    fp_sub = 32'h0000_0000;
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms_sh};
      if (mb == 24'h0) begin
        fp_sub = 32'h0000_0000;
      end else if (sum[24]) begin
        e_add = {1'b0, big[30:23]} + 9'd1;
        if (e_add >= 9'd255)
          fp_sub = {big[31], 8'hFE, 23'h7FFFFF};
        else
          fp_sub = {big[31], e_add[7:0], sum[23:1]};
      end else begin
        fp_sub = {big[31], big[30:23], sum[22:0]};
      end
    end else begin
      diff = mb - ms_sh;
      if (diff != 24'h0) begin
        // Lowest-to-highest scan: the highest set bit writes last.
        for (int i = 0; i < 24; i++)
          if (diff[i]) lz = 5'(23 - i);
        norm = diff << lz;
        en   = $signed({2'b00, big[30:23]}) - $signed({5'b00000, lz});
        if (en > 10'sd0)
          fp_sub = {big[31], en[7:0], norm[22:0]};
      end
    end
  endfunction

  function automatic class_t classify(input logic [31:0] x);
    if (x[30:23] == 8'h00)                           return C_DBZ;
    else if (x[30:23] == 8'hFF && x[22:0] != 23'h0)  return C_INVALID;
    else if (x[31])                                  return C_INVALID;
    else if (x[30:23] == 8'hFF)                      return C_PINF;
    else                                             return C_NORMAL;
  endfunction

  state_t      state, state_nxt;
  class_t      cls_q;
  logic [31:0] x_q, y_q, xhalf_q, t_q;
  logic [2:0]  k_q;
  logic [31:0] mul_a, mul_b, mul_res, sub_res, seed, y_final;
  logic        accept, load_out;

  assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    mul_a = y_q;
    mul_b = y_q;
    case (state)
      S_MXY: begin mul_a = xhalf_q; mul_b = t_q; end
      S_MY:  begin mul_a = y_q;     mul_b = t_q; end
      default: ;
    endcase
  end

  assign mul_res = fp_mul(mul_a, mul_b);
  assign sub_res = fp_sub(THREE_HALVES, t_q);
  assign seed    = MAGIC - (x_q >> 1);
  // With zero iterations DONE is entered straight from SEED.
  assign y_final = (state == S_SEED) ? seed : mul_res;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SEED;
      S_SEED: state_nxt = (ITERS == 3'd0) ? S_DONE : S_SQ;
      S_SQ:   state_nxt = S_MXY;
      S_MXY:  state_nxt = S_SUB;
      S_SUB:  state_nxt = S_MY;
      S_MY:   state_nxt = ((k_q + 3'd1) < ITERS) ? S_SQ : S_DONE;
      S_DONE: if (out_ready) state_nxt = accept ? S_SEED : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign load_out = (state != S_DONE) && (state_nxt == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cls_q       <= C_NORMAL;
      x_q         <= '0;
      y_q         <= '0;
      xhalf_q     <= '0;
      t_q         <= '0;
      k_q         <= '0;
      out_data    <= '0;
      out_invalid <= 1'b0;
      out_dbz     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q   <= in_data;
        cls_q <= classify(in_data);
      end
      case (state)
        S_SEED: begin
          y_q     <= seed;
          xhalf_q <= {x_q[31], x_q[30:23] - 8'd1, x_q[22:0]};
          k_q     <= 3'd0;
        end
        S_SQ:  t_q <= mul_res;
        S_MXY: t_q <= mul_res;
        S_SUB: t_q <= sub_res;
        S_MY: begin
          y_q <= mul_res;
          k_q <= k_q + 3'd1;
        end
        default: ;
      endcase
      if (load_out) begin
        case (cls_q)
          C_DBZ: begin
            out_data    <= {x_q[31], 8'hFF, 23'h0};
            out_invalid <= 1'b0;
            out_dbz     <= 1'b1;
          end
          C_INVALID: begin
            out_data    <= 32'h7FC0_0000;
            out_invalid <= 1'b1;
            out_dbz     <= 1'b0;
          end
          C_PINF: begin
            out_data    <= 32'h0000_0000;
            out_invalid <= 1'b0;
            out_dbz     <= 1'b0;
          end
          default: begin
            out_data    <= y_final;
            out_invalid <= 1'b0;
            out_dbz     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
